hrfp_add_align: RTL and testbench



---
 rtl/hrfp_pkg.sv | 37 +++
 rtl/hrfp_hex_shift_r.sv | 44 ++++
 rtl/hrfp_add_align.sv | 99 +++++++++
 tb/tb_hrfp_add_align.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hrfp_pkg.sv
// Shared HRFP constants and operand/result types for the adder, multiplier and normalize blocks.
// DIGITS is the number of hex digits in a mantissa. It is also the point where an alignment shift saturates.
package hrfp_pkg;

  localparam int EXP_W  = 7;
  localparam int MANT_W = 54;
  localparam int DIGITS = (MANT_W + 3) / 4;
  localparam int SH_W   = $clog2(DIGITS + 1);

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } hrfp_operand_t;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant_l;
    logic [MANT_W-1:0] mant_s;
    logic              sticky;
    logic              swap;
  } hrfp_aligned_t;

  typedef struct packed {
    logic [EXP_W-1:0]  exp_l;
    logic [MANT_W-1:0] mant_l;
    logic [MANT_W-1:0] mant_s_raw;
    logic [EXP_W-1:0]  diff;
    logic              swap;
  } hrfp_stage1_t;

  // Any exponent gap of DIGITS or more pushes the whole mantissa out.
  function automatic logic [SH_W-1:0] sat_digits(input logic [EXP_W-1:0] diff);
    if (int'(diff) >= DIGITS) return SH_W'(DIGITS);
    return SH_W'(diff);
  endfunction

endpackage

// File: rtl/hrfp_hex_shift_r.sv
// Combinational right shifter that moves data by whole hex digits, built as a log-depth barrel.
// The sticky output is the OR of every discarded bit when HRFP_ALIGN_STICKY_EN is defined. Otherwise it is tied to 0.
module hrfp_hex_shift_r #(
  parameter int MANT_W = 54,
  parameter int SH_W   = 4
) (
  input  logic [MANT_W-1:0] data_i,
  input  logic [SH_W-1:0]   digits_i,
  output logic [MANT_W-1:0] data_o,
  output logic              sticky_o
);

  logic [MANT_W-1:0] stage_w [SH_W+1];
`ifdef HRFP_ALIGN_STICKY_EN
  logic              lost_w  [SH_W+1];
  assign lost_w[0] = 1'b0;
`endif

  assign stage_w[0] = data_i;

  // Level gi moves the data 2**gi digits. It collects the bits that fall off the bottom at that level.
  for (genvar gi = 0; gi < SH_W; gi++) begin : g_level
    localparam int SB = 4 * (2 ** gi);
    if (SB < MANT_W) begin : g_part
      assign stage_w[gi+1] = digits_i[gi] ? (stage_w[gi] >> SB) : stage_w[gi];
`ifdef HRFP_ALIGN_STICKY_EN
      assign lost_w[gi+1] = lost_w[gi] | (digits_i[gi] & (|stage_w[gi][SB-1:0]));
`endif
    end else begin : g_full
      assign stage_w[gi+1] = digits_i[gi] ? '0 : stage_w[gi];
`ifdef HRFP_ALIGN_STICKY_EN
      assign lost_w[gi+1] = lost_w[gi] | (digits_i[gi] & (|stage_w[gi]));
`endif
    end
  end

  assign data_o = stage_w[SH_W];
`ifdef HRFP_ALIGN_STICKY_EN
  assign sticky_o = lost_w[SH_W];
`else
  assign sticky_o = 1'b0;
`endif

endmodule

// File: rtl/hrfp_add_align.sv
// HRFP adder pre-alignment. Stage 1 picks the larger exponent and the swap. Stage 2 right-shifts the smaller mantissa by digits.
// The sticky output is live only when HRFP_ALIGN_STICKY_EN is defined.
module hrfp_add_align
  import hrfp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp_a,
  input  logic [MANT_W-1:0] in_mant_a,
  input  logic [EXP_W-1:0]  in_exp_b,
  input  logic [MANT_W-1:0] in_mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant_l,
  output logic [MANT_W-1:0] out_mant_s,
  output logic              out_sticky,
  output logic              out_swap
);

  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  hrfp_stage1_t  s1_q, s1_d;
  hrfp_aligned_t s2_q, s2_d;

  hrfp_operand_t     op_a, op_b;
  logic              swap_w, s2_adv, in_fire;
  logic [SH_W-1:0]   sh_w;
  logic [MANT_W-1:0] shifted_w;
  logic              sticky_w;

  assign op_a = '{exp: in_exp_a, mant: in_mant_a};
  assign op_b = '{exp: in_exp_b, mant: in_mant_b};

  // out_ready only reaches in_ready. It never reaches out_valid.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  assign swap_w = op_b.exp > op_a.exp;

  always_comb begin
    s1_d = s1_q;
    if (in_fire) begin
      s1_d.exp_l      = swap_w ? op_b.exp  : op_a.exp;
      s1_d.mant_l     = swap_w ? op_b.mant : op_a.mant;
      s1_d.mant_s_raw = swap_w ? op_a.mant : op_b.mant;
      s1_d.diff       = swap_w ? (op_b.exp - op_a.exp) : (op_a.exp - op_b.exp);
      s1_d.swap       = swap_w;
    end
  end

  assign sh_w = sat_digits(s1_q.diff);

  hrfp_hex_shift_r #(
    .MANT_W (MANT_W),
    .SH_W   (SH_W)
  ) u_shift (
    .data_i   (s1_q.mant_s_raw),
    .digits_i (sh_w),
    .data_o   (shifted_w),
    .sticky_o (sticky_w)
  );

  always_comb begin
    s2_d = s2_q;
    if (s2_adv && s1_valid_q) begin
      s2_d = '{exp: s1_q.exp_l, mant_l: s1_q.mant_l, mant_s: shifted_w,
               sticky: sticky_w, swap: s1_q.swap};
    end
  end

  assign s1_valid_d = in_fire ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_exp    = s2_q.exp;
  assign out_mant_l = s2_q.mant_l;
  assign out_mant_s = s2_q.mant_s;
  assign out_sticky = s2_q.sticky;
  assign out_swap   = s2_q.swap;

endmodule

// File: tb/tb_hrfp_add_align.sv
// Directed bench for hrfp_add_align. Expected sticky follows HRFP_ALIGN_STICKY_EN in the same way as the build.
module tb_hrfp_add_align;

`ifdef HRFP_ALIGN_STICKY_EN
  localparam logic SE = 1'b1;
`else
  localparam logic SE = 1'b0;
`endif

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  in_exp_a, in_exp_b, out_exp;
  logic [53:0] in_mant_a, in_mant_b, out_mant_l, out_mant_s;
  logic        out_sticky, out_swap;

  int total = 0;
  int bad   = 0;

  hrfp_add_align dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_exp_a   (in_exp_a),
    .in_mant_a  (in_mant_a),
    .in_exp_b   (in_exp_b),
    .in_mant_b  (in_mant_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_exp    (out_exp),
    .out_mant_l (out_mant_l),
    .out_mant_s (out_mant_s),
    .out_sticky (out_sticky),
    .out_swap   (out_swap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Issue one pair into an empty pipe, check the 2-cycle latency and the fields, then drain.
  task automatic run_vec(input string tag,
                         input logic [6:0] ea, input logic [53:0] ma,
                         input logic [6:0] eb, input logic [53:0] mb,
                         input logic [6:0] x_exp, input logic [53:0] x_l,
                         input logic [53:0] x_s, input logic x_st, input logic x_sw);
    in_exp_a = ea; in_mant_a = ma; in_exp_b = eb; in_mant_b = mb;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".lat1_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, ".valid"},  64'(out_valid), 64'd1);
    chk({tag, ".exp"},    64'(out_exp), 64'(x_exp));
    chk({tag, ".mant_l"}, 64'(out_mant_l), 64'(x_l));
    chk({tag, ".mant_s"}, 64'(out_mant_s), 64'(x_s));
    chk({tag, ".sticky"}, 64'(out_sticky), 64'(x_st & SE));
    chk({tag, ".swap"},   64'(out_swap), 64'(x_sw));
    $display("vec %s: exp=%0h l=%0h s=%0h st=%0b sw=%0b", tag, out_exp, out_mant_l, out_mant_s, out_sticky, out_swap);
    @(posedge clk); #1;
  endtask

  function automatic void model(input logic [6:0] ea, input logic [6:0] eb,
                                input logic [53:0] ma, input logic [53:0] mb,
                                output logic [6:0] xe, output logic [53:0] xl,
                                output logic [53:0] xs, output logic xst, output logic xsw);
    int d, sh;
    logic [63:0] s64;
    xsw = eb > ea;
    d   = xsw ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
    sh  = (d > 14) ? 14 : d;
    xe  = xsw ? eb : ea;
    xl  = xsw ? mb : ma;
    s64 = {10'b0, (xsw ? ma : mb)};
    xs  = 54'(s64 >> (4 * sh));
    xst = SE && ((s64 & ((64'd1 << (4 * sh)) - 64'd1)) != 64'd0);
  endfunction

  logic [6:0]  v_ea [8], v_eb [8], x_e [8];
  logic [53:0] v_ma [8], v_mb [8], x_l [8], x_s [8];
  logic        x_st [8], x_sw [8];

  initial begin
    int sent, got, cyc, drops;
    logic acc, fire;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_exp_a = '0; in_exp_b = '0; in_mant_a = '0; in_mant_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready), 64'd1);
    chk("rst.exp",       64'(out_exp), 64'd0);
    chk("rst.mant_l",    64'(out_mant_l), 64'd0);
    chk("rst.mant_s",    64'(out_mant_s), 64'd0);
    chk("rst.sticky_swap", {62'd0, out_sticky, out_swap}, 64'd0);
    @(posedge clk); #1;

    run_vec("t1_tie", 7'h41, 54'h10_0000_0000_0000, 7'h41, 54'h18_0000_0000_0000,
            7'h41, 54'h10_0000_0000_0000, 54'h18_0000_0000_0000, 1'b0, 1'b0);
    run_vec("t2_swap", 7'h40, 54'h3_0000_0000_0001, 7'h42, 54'h20_0000_0000_0000,
            7'h42, 54'h20_0000_0000_0000, 54'h300_0000_0000, 1'b1, 1'b1);
    run_vec("t3_sat", 7'h50, 54'h3F_FFFF_0000_0000, 7'h3C, 54'h1,
            7'h50, 54'h3F_FFFF_0000_0000, 54'h0, 1'b1, 1'b0);
    run_vec("t3_sat_zero", 7'h50, 54'h3F_FFFF_0000_0000, 7'h3C, 54'h0,
            7'h50, 54'h3F_FFFF_0000_0000, 54'h0, 1'b0, 1'b0);
    run_vec("d13", 7'h10, 54'h2C_0000_0000_0001, 7'h1D, 54'h11_1111_1111_1111,
            7'h1D, 54'h11_1111_1111_1111, 54'h2, 1'b1, 1'b1);
    run_vec("d14", 7'h10, 54'h2C_0000_0000_0001, 7'h1E, 54'h11_1111_1111_1111,
            7'h1E, 54'h11_1111_1111_1111, 54'h0, 1'b1, 1'b1);
    run_vec("d1_exact", 7'h05, 54'h3_0000_0000_0000, 7'h04, 54'h123_4560,
            7'h05, 54'h3_0000_0000_0000, 54'h12_3456, 1'b0, 1'b0);
    run_vec("dmax", 7'h00, 54'h8, 7'h7F, 54'h0,
            7'h7F, 54'h0, 54'h0, 1'b1, 1'b1);
    run_vec("tie_zero", 7'h7F, 54'h0, 7'h7F, 54'h5,
            7'h7F, 54'h0, 54'h5, 1'b0, 1'b0);

    // Back-to-back stream with a 3-cycle downstream stall.
    for (int i = 0; i < 8; i++) begin
      v_ea[i] = 7'(8'h30 + i);
      v_eb[i] = 7'(8'h2C + 2 * i);
      v_ma[i] = 54'h15_A5A5_0000_0000 + 54'(i);
      v_mb[i] = 54'h2F_0000_1234_5678 ^ (54'(i) << 4);
      model(v_ea[i], v_eb[i], v_ma[i], v_mb[i], x_e[i], x_l[i], x_s[i], x_st[i], x_sw[i]);
    end
    sent = 0; got = 0; cyc = 0; drops = 0;
    while (got < 8 && cyc < 100) begin
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_exp_a = v_ea[sent]; in_mant_a = v_ma[sent];
        in_exp_b = v_eb[sent]; in_mant_b = v_mb[sent];
      end
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (!in_ready) drops++;
      if (fire) begin
        chk("b2b.exp",    64'(out_exp), 64'(x_e[got]));
        chk("b2b.mant_l", 64'(out_mant_l), 64'(x_l[got]));
        chk("b2b.mant_s", 64'(out_mant_s), 64'(x_s[got]));
        chk("b2b.sticky", 64'(out_sticky), 64'(x_st[got]));
        chk("b2b.swap",   64'(out_swap), 64'(x_sw[got]));
        $display("b2b out %0d: exp=%0h s=%0h st=%0b sw=%0b", got, out_exp, out_mant_s, out_sticky, out_swap);
      end
      @(posedge clk); #1;
      if (acc) sent++;
      if (fire) got++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b.count", 64'(got), 64'd8);
    chk("b2b.in_ready_dropped", 64'(drops > 0), 64'd1);
    @(posedge clk); #1;
    chk("b2b.no_dup", 64'(out_valid), 64'd0);

    // Fill both stages, then reset with an input still being offered.
    in_exp_a = 7'h22; in_mant_a = 54'h1234; in_exp_b = 7'h21; in_mant_b = 54'h5678;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("full.out_valid", 64'(out_valid), 64'd1);
    chk("full.in_ready",  64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst.out_valid", 64'(out_valid), 64'd0);
    chk("mrst.in_ready",  64'(in_ready), 64'd1);
    chk("mrst.exp",       64'(out_exp), 64'd0);
    chk("mrst.mants",     64'(out_mant_l | out_mant_s), 64'd0);
    chk("mrst.sticky_swap", {62'd0, out_sticky, out_swap}, 64'd0);
    $display("mid reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mrst.no_stale", 64'(out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
